// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- registered ALU with a multi-cycle shift-add multiplier.
//
// Operands are captured on an accepted start.  Single-cycle operations are
// evaluated in one EXEC cycle.  MUL runs WIDTH shift-add iterations.  Result
// and flags are held in flops until the next completion or reset.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   start      : request, sampled only in IDLE
//   a, b       : operands (WIDTH), captured with start
//   op         : {Binvert, Operation[1:0]}
//                000 AND  001 OR  010 ADD  110 SUB
//                100 ANDN 101 ORN 111 SLT  011 MUL
//   busy       : an accepted operation is in flight
//   done       : one-cycle pulse when result/flags update
//   result     : registered result (WIDTH)
//   carry_out  : adder carry (ADD/SUB/SLT), else 0
//   overflow   : signed overflow (ADD/SUB/SLT), upper product != 0 (MUL)
//   zero       : result == 0
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   localparam logic [2:0]       OP_MUL   = 3'b011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, mplier_q;
   logic [2:0]         op_q;
   logic [2*WIDTH-1:0] mcand_q, acc_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               busy_q, done_q, carry_q, ovf_q, zero_q;
   logic [WIDTH-1:0]   result_q;

   // Single-cycle datapath, evaluated from the captured operands only
   logic [WIDTH-1:0]   bp;
   logic [WIDTH:0]     sum_w;
   logic               add_ov;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   always_comb begin
      bp      = op_q[2] ? ~b_q : b_q;
      // Carry-in equals Binvert: a + ~b + 1 is the two's-complement subtract
      sum_w   = {1'b0, a_q} + {1'b0, bp} + {{WIDTH{1'b0}}, op_q[2]};
      add_ov  = (a_q[WIDTH-1] == bp[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q[1:0])
         2'b00: alu_res = a_q & bp;
         2'b01: alu_res = a_q | bp;
         2'b10: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = add_ov;
         end
         default: begin
            // Only SLT reaches EXEC with Operation=11; sign of the true
            // difference is the sum MSB corrected by overflow
            alu_res = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ov};
            alu_c   = sum_w[WIDTH];
            alu_v   = add_ov;
         end
      endcase
   end

   // Multiplier accumulate for the current iteration
   logic [2*WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  op_q   <= op;
                  busy_q <= 1'b1;
                  if (op == OP_MUL) begin
                     mcand_q  <= {{WIDTH{1'b0}}, a};
                     mplier_q <= b;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= S_MUL;
                  end else begin
                     state_q  <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               result_q <= alu_res;
               carry_q  <= alu_c;
               ovf_q    <= alu_v;
               zero_q   <= (alu_res == '0);
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               // Last iteration: publish straight from acc_d so the final
               // partial product is included
               if (cnt_q == CNT_LAST) begin
                  result_q <= acc_d[WIDTH-1:0];
                  carry_q  <= 1'b0;
                  ovf_q    <= |acc_d[2*WIDTH-1:WIDTH];
                  zero_q   <= (acc_d[WIDTH-1:0] == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            default: begin
               // DONE: start is deliberately not sampled here
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
